freq_meter: RTL

Gated frequency counter for the board-bring-up designs: counts rising edges of an asynchronous pad signal over a fixed gate window derived from the board oscillator, then publishes the result once per window. It is the measuring counterpart of the clock divider that drives the LED. It sits beside the reset generator in a top level, takes its reset, and drives a display, a UART formatter, or a loopback self-test.

---
 rtl/freq_meter_pkg.sv | 21 ++
 rtl/freq_meter_sync_edge.sv | 37 +++
 rtl/freq_meter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/freq_meter_pkg.sv
// Shared constants and helpers for the gated frequency meter.
package freq_meter_pkg;

  // Top-level FSM encoding.
  localparam logic [0:0] ST_WARM = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Last value of the settle counter before measurement starts.
  localparam logic [1:0] SETTLE_LAST = 2'd2;

  // Gate window length in oscillator cycles.
  function automatic int gate_len(input int clock_hz, input int rate_hz);
    return clock_hz / rate_hz;
  endfunction

  // Width of the gate counter that spans 0..g-1.
  function automatic int gate_width(input int g);
    return (g <= 2) ? 1 : $clog2(g);
  endfunction

endpackage

// File: rtl/freq_meter_sync_edge.sv
// Two-flop synchronizer plus history flop; flags a rising edge of an
// asynchronous input when enabled.
module sync_edge (
  input  logic clock,
  input  logic reset,
  input  logic in,
  input  logic en,
  output logic rise
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic p_q,  p_d;

  // Next-state of the synchronizer chain and history flop.
  always_comb begin
    s1_d = in;
    s2_d = s1_q;
    p_d  = s2_q;
  end

  // Synchronizer and history registers, cleared by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      p_q  <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      p_q  <= p_d;
    end
  end

  assign rise = s2_q & ~p_q & en;

endmodule

// File: rtl/freq_meter.sv
// Gated frequency counter: counts rising edges of an asynchronous input over
// back-to-back windows of CLOCK/RATE cycles and publishes one result per window.
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int CLOCK = 25_000_000,
  parameter int RATE  = 1,
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in,
  output logic [WIDTH-1:0] count,
  output logic             valid,
  output logic             over
);

  localparam int              G      = gate_len(CLOCK, RATE);
  localparam int              GW     = gate_width(G);
  localparam logic [GW-1:0]   G_LAST = GW'(G - 1);
  localparam logic [WIDTH-1:0] ACC_MAX = {WIDTH{1'b1}};

  logic [0:0]       state_q, state_d;
  logic [1:0]       settle_q, settle_d;
  logic [GW-1:0]    g_q, g_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             sat_q, sat_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             over_q, over_d;
  logic             valid_q, valid_d;

  logic             run_s;
  logic             rise_s;
  logic             close_s;
  logic             acc_full_s;
  logic             sat_hit_s;
  logic [WIDTH-1:0] acc_inc_s;

  assign run_s = (state_q == ST_RUN);

  sync_edge u_sync_edge (
    .clock (clock),
    .reset (reset),
    .in    (in),
    .en    (run_s),
    .rise  (rise_s)
  );

  // Edge arithmetic shared by the accumulate and window-close paths.
  always_comb begin
    close_s    = run_s & (g_q == G_LAST);
    acc_full_s = (acc_q == ACC_MAX);
    sat_hit_s  = rise_s & acc_full_s;
    if (rise_s && !acc_full_s) begin
      acc_inc_s = acc_q + WIDTH'(1);
    end else begin
      acc_inc_s = acc_q;
    end
  end

  // FSM: settle the input path for three cycles, then run gate windows forever.
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    g_d      = g_q;
    case (state_q)
      ST_WARM: begin
        g_d = {GW{1'b0}};
        if (settle_q == SETTLE_LAST) begin
          state_d  = ST_RUN;
          settle_d = 2'd0;
        end else begin
          settle_d = settle_q + 2'd1;
        end
      end
      ST_RUN: begin
        if (g_q == G_LAST) begin
          g_d = {GW{1'b0}};
        end else begin
          g_d = g_q + GW'(1);
        end
      end
      default: begin
        state_d  = ST_WARM;
        settle_d = 2'd0;
        g_d      = {GW{1'b0}};
      end
    endcase
  end

  // Accumulator and published results; the closing cycle's edge joins the closing window.
  always_comb begin
    acc_d   = acc_q;
    sat_d   = sat_q;
    count_d = count_q;
    over_d  = over_q;
    valid_d = 1'b0;
    if (close_s) begin
      count_d = acc_inc_s;
      over_d  = sat_q | sat_hit_s;
      valid_d = 1'b1;
      acc_d   = {WIDTH{1'b0}};
      sat_d   = 1'b0;
    end else if (run_s) begin
      acc_d = acc_inc_s;
      sat_d = sat_q | sat_hit_s;
    end else begin
      acc_d = {WIDTH{1'b0}};
      sat_d = 1'b0;
    end
  end

  // State registers with synchronous reset; a reset discards any partial window.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_WARM;
      settle_q <= 2'd0;
      g_q      <= {GW{1'b0}};
      acc_q    <= {WIDTH{1'b0}};
      sat_q    <= 1'b0;
      count_q  <= {WIDTH{1'b0}};
      over_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      g_q      <= g_d;
      acc_q    <= acc_d;
      sat_q    <= sat_d;
      count_q  <= count_d;
      over_q   <= over_d;
      valid_q  <= valid_d;
    end
  end

  assign count = count_q;
  assign valid = valid_q;
  assign over  = over_q;

endmodule
